// File: rtl/simon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_pkg : shared sizing and level encodings for the Simon datapath      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package simon_pkg;
    localparam int   SIMON_WIDTH  = 4;
    localparam int   SIMON_DEPTH  = 64;
    localparam int   SIMON_ADDR_W = 7;
    localparam logic LEVEL_EASY   = 1'b0;
    localparam logic LEVEL_HARD   = 1'b1;
    localparam int   SCORE_W      = 8;
endpackage
`default_nettype wire

// File: rtl/simon_datapath_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_datapath_if : controller <-> datapath strobes and status flags     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface simon_datapath_if
    import simon_pkg::*;
#(
    parameter int WIDTH = SIMON_WIDTH
);
    logic [WIDTH-1:0]   pattern;
    logic               level;
    logic               level_enable;
    logic               write_enable;
    logic               counter_rst;
    logic               counter_enable;
    logic               current_rst;
    logic               current_enable;
    logic               display_choice;
    logic               pattern_valid;
    logic               pattern_same;
    logic               SeenAll;
    logic [WIDTH-1:0]   pattern_leds;
    logic [SCORE_W-1:0] score;

    modport master (
        output pattern, level, level_enable, write_enable, counter_rst,
               counter_enable, current_rst, current_enable, display_choice,
        input  pattern_valid, pattern_same, SeenAll, pattern_leds, score
    );

    modport slave (
        input  pattern, level, level_enable, write_enable, counter_rst,
               counter_enable, current_rst, current_enable, display_choice,
        output pattern_valid, pattern_same, SeenAll, pattern_leds, score
    );
endinterface
`default_nettype wire

// File: rtl/simon_pattern_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_pattern_mem : DEPTH x WIDTH register file, sync write, async read  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module simon_pattern_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/simon_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_datapath : pattern store, playback and compare for the Simon game  |
// | Optional: SIMON_SCORE_EN builds the rounds-completed (score) register.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module simon_datapath
    import simon_pkg::*;
#(
    parameter int WIDTH  = SIMON_WIDTH,
    parameter int DEPTH  = SIMON_DEPTH,
    parameter int ADDR_W = SIMON_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    simon_datapath_if.slave bus
);
    localparam int MEM_AW = $clog2(DEPTH);

    logic              r_level;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_counter;

    logic              w_full;
    logic              w_empty;
    logic              w_onehot;
    logic              w_valid;
    logic              w_write;
    logic              w_at_end;
    logic [ADDR_W-1:0] w_last_m1;
    logic [WIDTH-1:0]  w_rdata;

    assign w_full    = (r_last == ADDR_W'(DEPTH));
    assign w_empty   = (r_last == '0);
    assign w_last_m1 = r_last - ADDR_W'(1);
    assign w_at_end  = w_empty || (r_counter == w_last_m1);
    assign w_onehot  = (bus.pattern != '0) &&
                       ((bus.pattern & (bus.pattern - WIDTH'(1))) == '0);
    assign w_valid   = !w_full && ((r_level == LEVEL_EASY) || w_onehot);
    assign w_write   = bus.write_enable && w_valid;

    // counter never exceeds last-1, so stopping at w_at_end is the saturation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level   <= LEVEL_EASY;
            r_last    <= '0;
            r_counter <= '0;
        end else begin
            if (bus.level_enable) begin
                r_level <= bus.level;
            end
            if (w_write) begin
                r_last <= r_last + ADDR_W'(1);
            end
            if (bus.counter_rst) begin
                r_counter <= '0;
            end else if (bus.counter_enable && !w_at_end) begin
                r_counter <= r_counter + ADDR_W'(1);
            end
        end
    end

    simon_pattern_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_write),
        .waddr (r_last[MEM_AW-1:0]),
        .wdata (bus.pattern),
        .raddr (r_counter[MEM_AW-1:0]),
        .rdata (w_rdata)
    );

    assign bus.pattern_valid = w_valid;
    assign bus.pattern_same  = !w_empty && (bus.pattern == w_rdata);
    assign bus.SeenAll       = w_at_end;
    assign bus.pattern_leds  = bus.display_choice ? (w_empty ? '0 : w_rdata)
                                                  : bus.pattern;

`ifdef SIMON_SCORE_EN
    logic [SCORE_W-1:0] r_current;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_current <= '0;
        end else if (bus.current_rst) begin
            r_current <= '0;
        end else if (bus.current_enable && (r_current != '1)) begin
            r_current <= r_current + SCORE_W'(1);
        end
    end

    assign bus.score = r_current;
`else
    logic w_unused_score_strobes;

    assign w_unused_score_strobes = bus.current_rst ^ bus.current_enable;
    assign bus.score              = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_simon_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_simon_datapath : randomized bench against a behavioural game model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_simon_datapath;
    import simon_pkg::*;

    localparam int W = SIMON_WIDTH;
    localparam int D = SIMON_DEPTH;
`ifdef SIMON_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    simon_datapath_if #(.WIDTH(W)) bus ();

    simon_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Game model: the stored list, how many entries, playback index, rounds
    logic [W-1:0] m_mem [D];
    int           m_last;
    int           m_counter;
    int           m_current;
    logic         m_level;

    function automatic logic m_valid();
        return (m_last < D) && (m_level == LEVEL_EASY || $countones(bus.pattern) == 1);
    endfunction

    function automatic logic [14:0] expected();
        logic [W-1:0] rd;
        logic [7:0]   sc;
        rd = (m_last == 0) ? '0 : m_mem[m_counter];
        sc = SCORE_ON ? 8'(m_current) : 8'd0;
        return {m_valid(), (m_last != 0) && (bus.pattern == rd),
                (m_last == 0) || (m_counter == m_last - 1),
                bus.display_choice ? rd : bus.pattern, sc};
    endfunction

    function automatic logic [14:0] observed();
        return {bus.pattern_valid, bus.pattern_same, bus.SeenAll, bus.pattern_leds, bus.score};
    endfunction

    task automatic model_reset();
        m_last = 0; m_counter = 0; m_current = 0; m_level = LEVEL_EASY;
    endtask

    task automatic idle();
        bus.level_enable = 0; bus.write_enable = 0; bus.counter_rst = 0;
        bus.counter_enable = 0; bus.current_rst = 0; bus.current_enable = 0;
        bus.display_choice = 0;
    endtask

    task automatic tick();
        logic v;
        int   old_last;
        v = m_valid();
        old_last = m_last;
        @(posedge clk);
        if (rst) begin
            if (bus.write_enable && v) begin
                m_mem[m_last] = bus.pattern;
                m_last++;
            end
            if (bus.level_enable) m_level = bus.level;
            if (bus.counter_rst) m_counter = 0;
            else if (bus.counter_enable && m_counter < old_last - 1) m_counter++;
            if (bus.current_rst) m_current = 0;
            else if (bus.current_enable && m_current < 255) m_current++;
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); model_reset();
        bus.level = LEVEL_HARD; bus.level_enable = 1; bus.pattern = 4'b0101;
        #2;
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL reset_out: got %b want %b", observed(), expected());
        end
        tick();
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL reset_hold: got %b want %b", observed(), expected());
        end
        rst = 1;
        tick();
        bus.level_enable = 0; bus.pattern = 4'b0101; #1;
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL hard_0101: got %b want %b", observed(), expected());
        end
        bus.pattern = 4'b0100; #1;
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL hard_0100: got %b want %b", observed(), expected());
        end
        for (int i = 0; i < 8; i++) begin
            bus.pattern = 4'($urandom); #1;
            n_vec++;
            if (observed() !== expected()) begin
                n_err++; $display("FAIL hard_rand: got %b want %b", observed(), expected());
            end
            tick();
        end
    endtask

    task automatic test_write_playback();
        idle();
        bus.level = LEVEL_EASY; bus.level_enable = 1; tick(); bus.level_enable = 0;
        bus.write_enable = 1;
        bus.pattern = 4'b0011; tick();
        bus.pattern = 4'b1000; tick();
        bus.write_enable = 0; bus.display_choice = 1; #1;
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL play0: got %b want %b", observed(), expected());
        end
        bus.counter_enable = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (observed() !== expected()) begin
                n_err++; $display("FAIL play_step%0d: got %b want %b", i, observed(), expected());
            end
        end
        bus.counter_enable = 0;
    endtask

    task automatic test_pattern_same();
        idle();
        bus.counter_rst = 1; bus.counter_enable = 1; tick(); idle();
        bus.pattern = 4'b0011; #1;
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL same_hit: got %b want %b", observed(), expected());
        end
        bus.pattern = 4'b0010; #1;
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL same_miss: got %b want %b", observed(), expected());
        end
        for (int i = 0; i < 10; i++) begin
            bus.pattern = 4'($urandom);
            bus.display_choice = 1'($urandom);
            bus.counter_enable = ($urandom_range(0, 3) == 0);
            #1;
            n_vec++;
            if (observed() !== expected()) begin
                n_err++; $display("FAIL same_rand: got %b want %b", observed(), expected());
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 40; i++) begin
            bus.pattern        = 4'($urandom);
            bus.level          = 1'($urandom);
            bus.level_enable   = ($urandom_range(0, 5) == 0);
            bus.write_enable   = 1'($urandom);
            bus.counter_rst    = ($urandom_range(0, 5) == 0);
            bus.counter_enable = 1'($urandom);
            bus.current_rst    = ($urandom_range(0, 7) == 0);
            bus.current_enable = 1'($urandom);
            bus.display_choice = 1'($urandom);
            #1;
            n_vec++;
            if (observed() !== expected()) begin
                n_err++; $display("FAIL b2b: got %b want %b", observed(), expected());
            end
            tick();
        end
        idle();
    endtask

    task automatic test_fill();
        logic [W-1:0] keep;
        idle();
        bus.level = LEVEL_EASY; bus.level_enable = 1; tick(); bus.level_enable = 0;
        bus.write_enable = 1;
        for (int i = 0; i < 2 * D && m_last < D; i++) begin
            bus.pattern = 4'($urandom); tick();
        end
        bus.write_enable = 0; #1;
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL full_valid: got %b want %b", observed(), expected());
        end
        keep = m_mem[D-1];
        bus.pattern = ~keep; bus.write_enable = 1; tick(); bus.write_enable = 0;
        bus.counter_rst = 1; tick(); bus.counter_rst = 0;
        bus.counter_enable = 1; bus.display_choice = 1;
        for (int i = 0; i < D + 4; i++) begin
            bus.pattern = 4'($urandom); #1;
            n_vec++;
            if (observed() !== expected()) begin
                n_err++; $display("FAIL walk%0d: got %b want %b", i, observed(), expected());
            end
            tick();
        end
        n_vec++;
        if (bus.pattern_leds !== keep) begin
            n_err++; $display("FAIL full_ignore: got %b want %b", bus.pattern_leds, keep);
        end
        idle();
    endtask

    task automatic test_score();
        idle();
        bus.current_rst = 1; tick(); bus.current_rst = 0;
        bus.current_enable = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (bus.score !== (SCORE_ON ? 8'(i + 1) : 8'd0)) begin
                n_err++; $display("FAIL score_inc: got %0d want %0d", bus.score, SCORE_ON ? i + 1 : 0);
            end
        end
        bus.current_enable = 0; bus.current_rst = 1; tick();
        n_vec++;
        if (bus.score !== 8'd0) begin
            n_err++; $display("FAIL score_rst: got %0d want 0", bus.score);
        end
        bus.current_rst = 0; bus.current_enable = 1;
        for (int i = 0; i < 260; i++) tick();
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL score_sat: got %b want %b", observed(), expected());
        end
        bus.current_rst = 1; tick();
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL score_prio: got %b want %b", observed(), expected());
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        rst = 0; model_reset(); #1; rst = 1;
        bus.write_enable = 1;
        bus.pattern = 4'($urandom); tick();
        bus.pattern = 4'($urandom); tick();
        bus.write_enable = 0; bus.counter_enable = 1; bus.current_enable = 1; tick();
        bus.counter_enable = 0; bus.current_enable = 0; bus.display_choice = 1;
        bus.pattern = m_mem[1]; #1;
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL pre_async: got %b want %b", observed(), expected());
        end
        #1; rst = 0; model_reset(); #1;
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL async_rst: got %b want %b", observed(), expected());
        end
        #1; rst = 1; tick();
        n_vec++;
        if (dut.u_mem.r_mem[0] !== m_mem[0]) begin
            n_err++; $display("FAIL mem_keep: got %b want %b", dut.u_mem.r_mem[0], m_mem[0]);
        end
        n_vec++;
        if (observed() !== expected()) begin
            n_err++; $display("FAIL post_async: got %b want %b", observed(), expected());
        end
    endtask

    initial begin
        bus.pattern = '0; bus.level = 0; idle();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        test_reset();
        test_write_playback();
        test_pattern_same();
        test_back_to_back();
        test_fill();
        test_score();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
